// File: rtl/e5m2_pkg.sv
// Shared constants, types and the FP16 -> fixed-point conversion for the
// E5M2 product accumulator. Optional MX scaling: E5M2_ACC_MX_SCALE_EN.
package e5m2_pkg;

  localparam int FP16_EXP_W    = 5;
  localparam int FP16_MAN_W    = 10;
  localparam int FP16_BIAS     = 15;
  localparam int FP32_EXP_W    = 8;
  localparam int FP32_MAN_W    = 23;
  localparam int FP32_BIAS     = 127;
  localparam int FIXED_LSB_EXP = -24;
  // Widest single product: {1,man} << 29 -> 40 magnitude bits plus sign.
  localparam int PROD_FIX_W    = 41;

  localparam logic [31:0] QNAN32 = 32'h7FC00000;
  localparam logic [31:0] PINF32 = 32'h7F800000;
  localparam logic [31:0] NINF32 = 32'hFF800000;

  typedef enum logic [1:0] {ACC, NORM, RND, OUT} state_e;

  typedef struct packed {
    logic nan;
    logic inf;
    logic inexact;
    logic len_err;
  } flags_t;

  // FP16 value as a signed integer in units of 2^FIXED_LSB_EXP.
  // exp=31 encodings are handled by the sticky flags and contribute 0.
  function automatic logic signed [PROD_FIX_W-1:0] fp16_to_fix(input logic [15:0] h);
    logic [FP16_EXP_W-1:0] e;
    logic [FP16_MAN_W-1:0] m;
    logic [PROD_FIX_W-1:0] mag;
    e = h[14:10];
    m = h[9:0];
    if (e == 5'd31)     mag = '0;
    else if (e == 5'd0) mag = PROD_FIX_W'(m);
    else                mag = PROD_FIX_W'({1'b1, m}) << (e - 5'd1);
    if (h[15]) mag = -mag;
    return $signed(mag);
  endfunction

endpackage

// File: rtl/e5m2_lzc.sv
// Parameterised leading-zero counter; an all-zero input returns W.
module e5m2_lzc #(
  parameter int W  = 46,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_i,
  output logic [CW-1:0] cnt_o
);

  // Ascending scan so the highest set bit wins.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (in_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/e5m2_acc_fp32.sv
// Exact fixed-point accumulator of FP16 products, emitting one FP32 result
// per vector. Optional E8M0 shared scaling: E5M2_ACC_MX_SCALE_EN.
module e5m2_acc_fp32
  import e5m2_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int ACC_W   = 41 + $clog2(MAX_LEN)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        prod_valid_i,
  output logic        prod_ready_o,
  input  logic [15:0] prod_i,
  input  logic        prod_last_i,
`ifdef E5M2_ACC_MX_SCALE_EN
  input  logic [7:0]  scale_a_i,
  input  logic [7:0]  scale_b_i,
`endif
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_o,
  output logic [3:0]  res_flags_o
);

  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int LZ_W    = $clog2(ACC_W + 1);
  localparam int EXP_OFS = FP32_BIAS + FIXED_LSB_EXP;

  state_e                    state_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      nan_q, pinf_q, ninf_q, len_err_q;
  logic [ACC_W-1:0]          norm_q;
  logic [7:0]                p_q;
  logic                      sign_q;
  logic                      ready_q, rvalid_q;
  logic [31:0]               res_q;
  flags_t                    flags_q;
`ifdef E5M2_ACC_MX_SCALE_EN
  logic [7:0]                sa_q, sb_q;
`endif

  // Beat conversion and accumulate
  logic signed [PROD_FIX_W-1:0] prod_fix;
  logic signed [ACC_W-1:0]      acc_d;
  logic                         beat, is_spec, spec_nan, max_hit, close;

  assign prod_fix = fp16_to_fix(prod_i);
  assign acc_d    = acc_q + {{(ACC_W-PROD_FIX_W){prod_fix[PROD_FIX_W-1]}}, prod_fix};
  assign beat     = prod_valid_i && ready_q;
  assign is_spec  = (prod_i[14:10] == 5'd31);
  assign spec_nan = is_spec && (prod_i[9:0] != 10'd0);
  assign max_hit  = (cnt_q == CNT_W'(MAX_LEN - 1));
  assign close    = prod_last_i || max_hit;

  // Normalisation: magnitude, leading zeros, left-align
  logic [ACC_W-1:0] mag, norm_d;
  logic [LZ_W-1:0]  lz;
  logic [7:0]       p_d;

  assign mag = acc_q[ACC_W-1] ? -acc_q : acc_q;

  e5m2_lzc #(.W(ACC_W)) u_lzc (
    .in_i  (mag),
    .cnt_o (lz)
  );

  assign norm_d = mag << lz;
  assign p_d    = 8'(ACC_W - 1) - 8'(lz);

  // Rounding: mantissa sits just below the aligned leading one
  logic [FP32_MAN_W-1:0]   mant, mant_r;
  logic                    grd, stk, rup, carry, scale_nan;
  logic signed [10:0]      exp_s;
  logic [31:0]             res_d;
  flags_t                  flags_d;

  assign mant = norm_q[ACC_W-2 -: FP32_MAN_W];
  assign grd  = norm_q[ACC_W-2-FP32_MAN_W];
  assign stk  = |norm_q[ACC_W-3-FP32_MAN_W:0];
  assign rup  = grd & (stk | mant[0]);
  assign {carry, mant_r} = {1'b0, mant} + 24'(rup);

`ifdef E5M2_ACC_MX_SCALE_EN
  assign scale_nan = (sa_q == 8'hFF) || (sb_q == 8'hFF);
  assign exp_s = 11'(p_q) + 11'(EXP_OFS) + 11'(carry) + 11'(sa_q) + 11'(sb_q) - 11'(2 * FP32_BIAS);
`else
  assign scale_nan = 1'b0;
  assign exp_s = 11'(p_q) + 11'(EXP_OFS) + 11'(carry);
`endif

  // Result selection with special-value priority; range checks only bite with scaling
  always_comb begin
    res_d           = '0;
    flags_d         = '0;
    flags_d.len_err = len_err_q;
    if (nan_q || (pinf_q && ninf_q) || scale_nan) begin
      res_d       = QNAN32;
      flags_d.nan = 1'b1;
    end else if (pinf_q) begin
      res_d       = PINF32;
      flags_d.inf = 1'b1;
    end else if (ninf_q) begin
      res_d       = NINF32;
      flags_d.inf = 1'b1;
    end else if (!norm_q[ACC_W-1]) begin
      res_d = '0;
    end else if (exp_s >= 11'sd255) begin
      res_d       = {sign_q, 8'hFF, 23'd0};
      flags_d.inf = 1'b1;
    end else if (exp_s <= 11'sd0) begin
      res_d           = {sign_q, 31'd0};
      flags_d.inexact = 1'b1;
    end else begin
      res_d           = {sign_q, exp_s[7:0], mant_r};
      flags_d.inexact = grd | stk;
    end
  end

  // Control FSM with all outputs registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      nan_q     <= 1'b0;
      pinf_q    <= 1'b0;
      ninf_q    <= 1'b0;
      len_err_q <= 1'b0;
      norm_q    <= '0;
      p_q       <= '0;
      sign_q    <= 1'b0;
      ready_q   <= 1'b1;
      rvalid_q  <= 1'b0;
      res_q     <= '0;
      flags_q   <= '0;
`ifdef E5M2_ACC_MX_SCALE_EN
      sa_q      <= 8'd127;
      sb_q      <= 8'd127;
`endif
    end else begin
      case (state_q)
        ACC: if (beat) begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (spec_nan)                nan_q  <= 1'b1;
          if (is_spec && !spec_nan) begin
            if (prod_i[15]) ninf_q <= 1'b1;
            else            pinf_q <= 1'b1;
          end
          if (close) begin
            state_q   <= NORM;
            ready_q   <= 1'b0;
            len_err_q <= max_hit && !prod_last_i;
`ifdef E5M2_ACC_MX_SCALE_EN
            sa_q      <= scale_a_i;
            sb_q      <= scale_b_i;
`endif
          end
        end
        NORM: begin
          norm_q  <= norm_d;
          p_q     <= p_d;
          sign_q  <= acc_q[ACC_W-1];
          state_q <= RND;
        end
        RND: begin
          res_q    <= res_d;
          flags_q  <= flags_d;
          rvalid_q <= 1'b1;
          state_q  <= OUT;
        end
        OUT: if (res_ready_i) begin
          rvalid_q  <= 1'b0;
          acc_q     <= '0;
          cnt_q     <= '0;
          nan_q     <= 1'b0;
          pinf_q    <= 1'b0;
          ninf_q    <= 1'b0;
          len_err_q <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= ACC;
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign prod_ready_o = ready_q;
  assign res_valid_o  = rvalid_q;
  assign res_o        = res_q;
  assign res_flags_o  = flags_q;

endmodule

// File: tb/tb_e5m2_acc_fp32.sv
// Self-checking bench for e5m2_acc_fp32: directed table, corner sequences,
// and random vectors against a value-level reference model.
module tb_e5m2_acc_fp32;

  logic        clk = 1'b0;
  logic        rst_i, prod_valid_i, prod_ready_o, prod_last_i;
  logic        res_valid_o, res_ready_i;
  logic [15:0] prod_i;
  logic [31:0] res_o;
  logic [3:0]  res_flags_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  e5m2_acc_fp32 dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .prod_valid_i (prod_valid_i),
    .prod_ready_o (prod_ready_o),
    .prod_i       (prod_i),
    .prod_last_i  (prod_last_i),
`ifdef E5M2_ACC_MX_SCALE_EN
    .scale_a_i    (8'd127),
    .scale_b_i    (8'd127),
`endif
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_o        (res_o),
    .res_flags_o  (res_flags_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Real-valued decode of an FP16 product, expressed in units of 2^-24.
  function automatic longint units(input logic [15:0] h);
    int  e, m;
    real v;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 31) return 0;
    if (e == 0) v = m / 1024.0;
    else        v = 1.0 + m / 1024.0;
    // subnormals share the 2^-14 scale of exponent 1
    for (int k = 0; k < ((e == 0) ? 1 : e) - 15 + 24; k++) v = v * 2.0;
    for (int k = 0; k < 15 - 24 - ((e == 0) ? 1 : e); k++) v = v / 2.0;
    return h[15] ? -longint'(v) : longint'(v);
  endfunction

  function automatic void ref_pack(input longint s, input bit nn, input bit pi, input bit ni,
                                   input bit le, output logic [31:0] r, output logic [3:0] f);
    longint mag, q, rem, half;
    int     p, sh;
    bit     sg;
    f = {3'b000, le};
    r = 32'd0;
    if (nn || (pi && ni)) begin
      r = 32'h7FC00000; f[3] = 1'b1;
    end else if (pi) begin
      r = 32'h7F800000; f[2] = 1'b1;
    end else if (ni) begin
      r = 32'hFF800000; f[2] = 1'b1;
    end else if (s != 0) begin
      sg  = (s < 0);
      mag = sg ? -s : s;
      p   = 0;
      while ((mag >> (p + 1)) != 0) p++;
      if (p <= 23) q = mag << (23 - p);
      else begin
        sh   = p - 23;
        q    = mag >> sh;
        rem  = mag - (q << sh);
        half = 64'sd1 << (sh - 1);
        if (rem != 0) f[1] = 1'b1;
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'sd1 << 24)) begin q = q >> 1; p++; end
      end
      r = {sg, 8'(p + 103), q[22:0]};
    end
  endfunction

  task automatic send_beat(input logic [15:0] d, input logic l);
    @(negedge clk);
    prod_valid_i = 1'b1; prod_i = d; prod_last_i = l;
    for (int i = 0; i < 100 && !prod_ready_o; i++) @(negedge clk);
    if (!prod_ready_o) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk); #1;
    prod_valid_i = 1'b0; prod_last_i = 1'b0;
  endtask

  task automatic get_result(input int dly, output logic [31:0] r, output logic [3:0] f);
    bit ok;
    ok = 1'b0; r = 'x; f = 'x;
    repeat (dly) @(negedge clk);
    @(negedge clk);
    res_ready_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (res_valid_o) begin ok = 1'b1; r = res_o; f = res_flags_o; break; end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    else begin
      n_tests++; n_fail++;
      $display("FAIL result_timeout: got no res_valid expected res_valid=1");
    end
    #1 res_ready_i = 1'b0;
  endtask

  function automatic logic [15:0] rand_beat();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(0, 24) == 0) h[14:10] = 5'd31;
    else if (h[14:10] == 5'd31) h[14:10] = 5'd30;
    if (h[14:10] == 5'd31 && $urandom_range(0, 1) == 0) h[9:0] = 10'd0;
    return h;
  endfunction

  typedef struct {
    int          n;
    logic [15:0] b [4];
    logic [31:0] er;
    logic [3:0]  ef;
  } vec_t;

  vec_t tbl [15];

  task automatic set_vec(input int i, input int n, input logic [15:0] b0, input logic [15:0] b1,
                         input logic [15:0] b2, input logic [15:0] b3,
                         input logic [31:0] er, input logic [3:0] ef);
    tbl[i].n = n;
    tbl[i].b[0] = b0; tbl[i].b[1] = b1; tbl[i].b[2] = b2; tbl[i].b[3] = b3;
    tbl[i].er = er; tbl[i].ef = ef;
  endtask

  initial begin
    logic [31:0] r, er;
    logic [3:0]  f, ef;
    logic [15:0] h;
    longint      s;
    bit          nn, pi, ni;
    int          len;

    rst_i = 1'b1; prod_valid_i = 1'b0; prod_i = '0; prod_last_i = 1'b0; res_ready_i = 1'b0;

    set_vec(0,  4, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 32'h40800000, 4'b0000);
    set_vec(1,  2, 16'h3C00, 16'hBC00, 16'h0000, 16'h0000, 32'h00000000, 4'b0000);
    set_vec(2,  2, 16'h0001, 16'h7BFF, 16'h0000, 16'h0000, 32'h477FE000, 4'b0010);
    set_vec(3,  2, 16'h7C00, 16'hFC00, 16'h0000, 16'h0000, 32'h7FC00000, 4'b1000);
    set_vec(4,  1, 16'hFC00, 16'h0000, 16'h0000, 16'h0000, 32'hFF800000, 4'b0100);
    set_vec(5,  1, 16'h7C01, 16'h0000, 16'h0000, 16'h0000, 32'h7FC00000, 4'b1000);
    set_vec(6,  3, 16'h3C00, 16'h3C00, 16'h3C00, 16'h0000, 32'h40400000, 4'b0000);
    set_vec(7,  1, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 32'h33800000, 4'b0000);
    set_vec(8,  2, 16'h3C00, 16'h0001, 16'h0000, 16'h0000, 32'h3F800000, 4'b0010);
    set_vec(9,  4, 16'h3C00, 16'h0001, 16'h0001, 16'h0001, 32'h3F800002, 4'b0010);
    set_vec(10, 2, 16'h4000, 16'h8001, 16'h0000, 16'h0000, 32'h40000000, 4'b0010);
    set_vec(11, 1, 16'hBC00, 16'h0000, 16'h0000, 16'h0000, 32'hBF800000, 4'b0000);
    set_vec(12, 3, 16'h7C00, 16'h3C00, 16'h3C00, 16'h0000, 32'h7F800000, 4'b0100);
    set_vec(13, 2, 16'h7C00, 16'h7C00, 16'h0000, 16'h0000, 32'h7F800000, 4'b0100);
    set_vec(14, 2, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 32'h00000000, 4'b0000);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk) rst_i = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(prod_ready_o), 32'd1);
    chk("rst_valid", 32'(res_valid_o), 32'd0);
    chk("rst_res", res_o, 32'd0);
    chk("rst_flags", 32'(res_flags_o), 32'd0);

    // latency and stall
    for (int k = 0; k < 4; k++) send_beat(16'h3C00, k == 3);
    chk("lat_t0", 32'(res_valid_o), 32'd0);
    @(posedge clk); #1 chk("lat_t1", 32'(res_valid_o), 32'd0);
    @(posedge clk); #1 chk("lat_t2", 32'(res_valid_o), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_res", res_o, 32'h40800000);
      chk("stall_ready", 32'(prod_ready_o), 32'd0);
    end
    get_result(0, r, f);
    chk("stall_final", r, 32'h40800000);

    // directed table
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < tbl[i].n; k++) send_beat(tbl[i].b[k], k == tbl[i].n - 1);
      get_result(i % 3, r, f);
      chk($sformatf("vec%0d_res", i), r, tbl[i].er);
      chk($sformatf("vec%0d_flags", i), 32'(f), 32'(tbl[i].ef));
    end

    // MAX_LEN beats without last
    for (int k = 0; k < 32; k++) send_beat(16'h7BFF, 1'b0);
    get_result(0, r, f);
    chk("len_res", r, 32'h49FFE000);
    chk("len_flags", 32'(f), 32'b0001);

    // reset mid-vector discards partial sum
    for (int k = 0; k < 3; k++) send_beat(16'h7BFF, 1'b0);
    @(negedge clk) rst_i = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_ready", 32'(prod_ready_o), 32'd1);
    chk("rstmid_valid", 32'(res_valid_o), 32'd0);
    @(negedge clk) rst_i = 1'b0;
    send_beat(16'h3C00, 1'b1);
    get_result(0, r, f);
    chk("rstmid_res", r, 32'h3F800000);
    chk("rstmid_flags", 32'(f), 32'd0);

    // reset while a result is pending
    send_beat(16'h7C01, 1'b1);
    repeat (2) @(posedge clk);
    #1 chk("rstout_pre", 32'(res_valid_o), 32'd1);
    @(negedge clk) rst_i = 1'b1;
    @(posedge clk); #1;
    chk("rstout_valid", 32'(res_valid_o), 32'd0);
    chk("rstout_res", res_o, 32'd0);
    chk("rstout_flags", 32'(res_flags_o), 32'd0);
    @(negedge clk) rst_i = 1'b0;
    send_beat(16'hBC00, 1'b1);
    get_result(0, r, f);
    chk("rstout_next", r, 32'hBF800000);
    chk("rstout_nflags", 32'(f), 32'd0);

    // random vectors against the reference model
    for (int v = 0; v < 150; v++) begin
      len = $urandom_range(1, 8);
      s = 0; nn = 1'b0; pi = 1'b0; ni = 1'b0;
      for (int k = 0; k < len; k++) begin
        h = rand_beat();
        if (h[14:10] == 5'd31) begin
          if (h[9:0] != 10'd0) nn = 1'b1;
          else if (h[15])      ni = 1'b1;
          else                 pi = 1'b1;
        end
        s += units(h);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_beat(h, k == len - 1);
      end
      ref_pack(s, nn, pi, ni, 1'b0, er, ef);
      get_result($urandom_range(0, 3), r, f);
      chk($sformatf("rnd%0d_res", v), r, er);
      chk($sformatf("rnd%0d_flags", v), 32'(f), 32'(ef));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/e5m2_acc_fp32.md
Name: e5m2_acc_fp32

Overview:
- Downstream of the E5M2 multiplier; consumes its FP16-format products (1/5/10) one per beat.
- Accumulates exactly in a wide two's-complement fixed-point register and emits one FP32 dot-product result per vector, marked by last.
- Supplies the accumulate half of the tensor-core MAC lane.

Parameters:
- MAX_LEN, 32, max beats per vector; sets accumulator headroom.
- ACC_W, 41+$clog2(MAX_LEN), signed accumulator width; derived, do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- prod_valid_i  in  1  product beat valid.
- prod_ready_o  out  1  accumulator accepts beat.
- prod_i  in  16  FP16 product.
- prod_last_i  in  1  final beat of vector.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer accepts result.
- res_o  out  32  FP32 result.
- res_flags_o  out  4  {nan, inf, inexact, len_err}.

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous, active-high.
- Reset:
  - state=ACC, accumulator=0, beat count=0, sticky specials cleared.
  - res_valid_o=0, res_o=0, res_flags_o=0, prod_ready_o=1 the cycle after reset.
- Handshake:
  - A beat transfers when prod_valid_i && prod_ready_o.
  - A result transfers when res_valid_o && res_ready_i.
  - res_o and res_flags_o stay stable while res_valid_o=1 and res_ready_i=0.
- FSM: ACC -> NORM -> RND -> OUT -> ACC.
  - prod_ready_o=1 only in ACC.
  - ACC -> NORM on an accepted beat with prod_last_i=1, or on the MAX_LEN-th beat (sets len_err).
  - NORM: leading-zero count and alignment.
  - RND: round to nearest even, pack, set res_valid_o. Last beat at cycle t gives res_valid_o=1 at t+2.
  - OUT -> ACC on result transfer; accumulator, count and sticky bits clear in the same edge.
- Fixed-point conversion, LSB = 2^-24:
  - Normal product: {1,man} << (exp-1).
  - Subnormal product: man.
  - Zero: 0.
  - Negate if sign; sign-extend to ACC_W; add.
  - The sum is exact and cannot overflow within MAX_LEN beats.
- Specials, exp=31:
  - man != 0 sets sticky nan.
  - man == 0 sets sticky pinf or ninf.
  - Specials contribute 0 to the accumulator.
- Packing, highest set bit p of |acc|:
  - Biased exponent = p+103; always normal.
  - p <= 23: exact, left-align.
  - p > 23: RNE using guard and sticky. inexact=1 when any dropped bit is 1. A rounding carry increments the exponent.
- Result priority:
  - nan, or both pinf and ninf: 0x7FC00000, nan=1.
  - Only pinf: 0x7F800000, inf=1.
  - Only ninf: 0xFF800000, inf=1.
  - Zero sum: 0x00000000; never -0.
- rst_i asserted in any state, including mid-vector or in OUT: return to reset values next edge; the partial vector is discarded.

Optional Feature:
- Macro: E5M2_ACC_MX_SCALE_EN.
- Enabled:
  - Adds ports scale_a_i [7:0] and scale_b_i [7:0] (E8M0 shared scales), sampled on the last accepted beat.
  - RND adds (scale_a-127)+(scale_b-127) to the FP32 exponent.
  - Either scale = 0xFF: NaN.
  - Biased exponent >= 255: ±inf with inf=1.
  - Biased exponent <= 0: signed zero with inexact=1.
- Disabled: ports absent; scale treated as 2^0.

Decomposition:
- Package e5m2_pkg:
  - FP16/FP32 field widths and biases (15, 127).
  - FIXED_LSB_EXP = -24.
  - QNAN32 = 32'h7FC00000.
  - State enum {ACC, NORM, RND, OUT}.
  - Packed flags struct.
- Sub-module: e5m2_lzc, parameterised-width leading-zero counter used in NORM.

Test Plan:
- 4 beats of 0x3C00, last on 4th: res_o=0x40800000, flags=0, res_valid_o exactly 2 cycles after the last beat.
- 0x3C00 then 0xBC00 (last): res_o=0x00000000, flags=0.
- 0x0001 then 0x7BFF (last): res_o=0x477FE000, inexact=1.
- 0x7C00 then 0xFC00 (last): res_o=0x7FC00000, nan=1. Single 0xFC00 (last): res_o=0xFF800000, inf=1.
- 32 beats of 0x7BFF, no last: res_o=0x49FFE000, len_err=1.
- Hold res_ready_i=0 for 5 cycles: res_o stable, prod_ready_o=0. Assert rst_i mid-vector: outputs return to reset values, and the next vector's result is unaffected.
